axi_mem_responder: RTL and testbench

AXI4 slave memory model and on-chip responder serving the DMA controller's AXI master port. It accepts one write or read transaction at a time on the five AXI channels and backs it with a word-addressed internal RAM. It gives the TinySIMT DRAM path a synthesizable target for simulation and for FPGA builds without external DRAM. It supports single-beat and FIXED/INCR bursts, byte strobes, and error responses.

---
 rtl/axi_mem_responder_if.sv | 73 +++++++
 rtl/axi_mem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// rtl/axi_mem_responder_if.sv - AXI4 five-channel bundle between a master and the memory responder
// Ports (through modports):
//   slave  : AW/W/AR payload+valid in, B/R payload+valid out, *ready out for AW/W/AR, bready/rready in
//   master : mirror image of slave
interface axi_mem_responder_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [3:0]            awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;

   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [3:0]            bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [3:0]            arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;

   logic [3:0]            rid;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 slave backed by a word-addressed internal RAM, one transaction at a time
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   s_axi  : AXI4 slave port (AW, W, B, AR, R channels); lock/cache/prot are ignored
// Parameters: ADDR_WIDTH (address bits), MEM_WORDS (RAM depth, 32-bit words), BASE_ADDR (byte address of word 0)
module axi_mem_responder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    MEM_WORDS  = 16384,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                clk,
   input  logic                reset,
   axi_mem_responder_if.slave  s_axi
);
   localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_FETCH, R_DATA} state_t;

   state_t                state_q, state_d;
   logic [3:0]            id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  size_err_q, size_err_d;
   logic                  burst_err_q, burst_err_d;
   logic                  fixed_q, fixed_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  rlast_q, rlast_d;
   logic                  rzero_q, rzero_d;
   logic [31:0]           ram_rdata_q;

   logic [31:0]           mem [0:MEM_WORDS-1];

   // Beat address decode; addr[1:0] do not select anything.
   logic [ADDR_WIDTH-1:0] off;
   logic                  in_range;
   logic [IDX_W-1:0]      word_idx;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  last_beat;
   logic [1:0]            w_beat_resp;
   logic                  mem_we;

   assign off       = addr_q - BASE_ADDR;
   assign in_range  = (addr_q >= BASE_ADDR) &&
                      ({2'b00, off[ADDR_WIDTH-1:2]} < ADDR_WIDTH'(MEM_WORDS));
   assign word_idx  = off[IDX_W+1:2];
   assign next_addr = fixed_q ? addr_q : addr_q + ADDR_WIDTH'(4);
   assign last_beat = (cnt_q == len_q);

   // Response codes are ordered so that the numerically larger one is the more severe.
   function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      size_err_d  = size_err_q;
      burst_err_d = burst_err_q;
      fixed_d     = fixed_q;
      bresp_d     = bresp_q;
      rresp_d     = rresp_q;
      rlast_d     = rlast_q;
      rzero_d     = rzero_q;
      w_beat_resp = RESP_OKAY;

      unique case (state_q)
         IDLE: begin
            // awready is 1 in IDLE, so awvalid alone is an AW handshake and wins over AR.
            if (s_axi.awvalid) begin
               id_d        = s_axi.awid;
               addr_d      = s_axi.awaddr;
               len_d       = s_axi.awlen;
               cnt_d       = '0;
               size_err_d  = (s_axi.awsize != 3'b010);
               burst_err_d = s_axi.awburst[1];
               fixed_d     = (s_axi.awburst == 2'b00);
               bresp_d     = ((s_axi.awsize != 3'b010) || s_axi.awburst[1]) ? RESP_SLVERR : RESP_OKAY;
               state_d     = W_DATA;
            end else if (s_axi.arvalid) begin
               id_d        = s_axi.arid;
               addr_d      = s_axi.araddr;
               len_d       = s_axi.arlen;
               cnt_d       = '0;
               size_err_d  = (s_axi.arsize != 3'b010);
               burst_err_d = s_axi.arburst[1];
               fixed_d     = (s_axi.arburst == 2'b00);
               state_d     = R_FETCH;
            end
         end
         W_DATA: begin
            if (s_axi.wvalid) begin
               if (!in_range)
                  w_beat_resp = RESP_DECERR;
               else if (s_axi.wlast != last_beat)
                  w_beat_resp = RESP_SLVERR;
               bresp_d = worse(bresp_q, w_beat_resp);
               addr_d  = next_addr;
               // The beat count, not wlast, decides where the burst ends.
               if (last_beat)
                  state_d = W_RESP;
               else
                  cnt_d = cnt_q + 8'd1;
            end
         end
         W_RESP: begin
            if (s_axi.bready)
               state_d = IDLE;
         end
         R_FETCH: begin
            rlast_d = last_beat;
            rzero_d = !in_range || size_err_q;
            if (!in_range)
               rresp_d = RESP_DECERR;
            else if (size_err_q || burst_err_q)
               rresp_d = RESP_SLVERR;
            else
               rresp_d = RESP_OKAY;
            state_d = R_DATA;
         end
         R_DATA: begin
            if (s_axi.rready) begin
               if (rlast_q) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = cnt_q + 8'd1;
                  addr_d  = next_addr;
                  state_d = R_FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         size_err_q  <= 1'b0;
         burst_err_q <= 1'b0;
         fixed_q     <= 1'b0;
         bresp_q     <= RESP_OKAY;
         rresp_q     <= RESP_OKAY;
         rlast_q     <= 1'b0;
         rzero_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         size_err_q  <= size_err_d;
         burst_err_q <= burst_err_d;
         fixed_q     <= fixed_d;
         bresp_q     <= bresp_d;
         rresp_q     <= rresp_d;
         rlast_q     <= rlast_d;
         rzero_q     <= rzero_d;
      end
   end

   // Burst-type errors still write; only range and size errors protect the RAM.
   assign mem_we = (state_q == W_DATA) && s_axi.wvalid && in_range && !size_err_q && !reset;

   // RAM contents are never reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (s_axi.wstrb[i])
               mem[word_idx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
         end
      end
   end

   // Read port register only loads in R_FETCH, so rdata holds through an R stall.
   always_ff @(posedge clk) begin
      if (reset)
         ram_rdata_q <= '0;
      else if (state_q == R_FETCH)
         ram_rdata_q <= mem[word_idx];
   end

   assign s_axi.awready = (state_q == IDLE);
   assign s_axi.arready = (state_q == IDLE) && !s_axi.awvalid;
   assign s_axi.wready  = (state_q == W_DATA);
   assign s_axi.bvalid  = (state_q == W_RESP);
   assign s_axi.bid     = id_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = (state_q == R_DATA);
   assign s_axi.rid     = id_q;
   assign s_axi.rdata   = rzero_q ? 32'h0 : ram_rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rlast   = rlast_q;

   logic unused_ok;
   assign unused_ok = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                        s_axi.arlock, s_axi.arcache, s_axi.arprot, off[1:0]};
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - directed vector bench for axi_mem_responder
module tb_axi_mem_responder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   axi_mem_responder_if #(.ADDR_WIDTH(32)) axi ();

   axi_mem_responder #(
      .ADDR_WIDTH(32),
      .MEM_WORDS (16384),
      .BASE_ADDR (32'h0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .s_axi(axi)
   );

   typedef struct {
      logic        wr;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int stable_bad;

   logic [31:0] wd   [16];
   logic [3:0]  ws   [16];
   logic [31:0] rd   [16];
   logic [1:0]  rr   [16];
   logic        rl   [16];
   logic [3:0]  rids [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                           input int last_idx, output logic [1:0] resp, output logic [3:0] bid,
                           output int waits);
      int n;
      waits = 0;
      axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
      axi.awvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!axi.awready && n < 50) begin n++; @(negedge clk); end
      waits += n;
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         axi.wdata = wd[b]; axi.wstrb = ws[b]; axi.wlast = (b == last_idx); axi.wvalid = 1'b1;
         n = 0;
         @(negedge clk);
         while (!axi.wready && n < 50) begin n++; @(negedge clk); end
         waits += n;
         @(posedge clk); #1;
      end
      axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.bready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!axi.bvalid && n < 50) begin n++; @(negedge clk); end
      waits += n;
      resp = axi.bresp;
      bid  = axi.bid;
      @(posedge clk); #1;
      axi.bready = 1'b0;
   endtask

   // waits accumulates deviation from the expected single R_FETCH cycle before every beat.
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input int stall_beat, input int stall_cycles, output int waits);
      int n;
      stable_bad = 0;
      axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
      axi.arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!axi.arready && n < 50) begin n++; @(negedge clk); end
      waits = n;
      @(posedge clk); #1;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b1;
      for (int b = 0; b < nbeats; b++) begin
         n = 0;
         @(negedge clk);
         while (!axi.rvalid && n < 50) begin n++; @(negedge clk); end
         waits += (n > 1) ? n - 1 : 1 - n;
         rd[b] = axi.rdata; rr[b] = axi.rresp; rl[b] = axi.rlast; rids[b] = axi.rid;
         if (b == stall_beat) begin
            axi.rready = 1'b0;
            repeat (stall_cycles) begin
               @(negedge clk);
               if (!axi.rvalid || axi.rdata !== rd[b] || axi.rresp !== rr[b] || axi.rlast !== rl[b])
                  stable_bad++;
            end
            axi.rready = 1'b1;
         end
         @(posedge clk); #1;
      end
      axi.rready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      vec_t        vecs [17];
      logic [1:0]  resp;
      logic [3:0]  bid;
      int          waits;
      int          n;

      vecs[0]  = '{1'b1, 4'h3, 32'h0000_0010, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
      vecs[1]  = '{1'b0, 4'h5, 32'h0000_0010, 3'd2, 2'b01, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 4'h1, 32'h0000_0020, 3'd2, 2'b01, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
      vecs[3]  = '{1'b1, 4'h2, 32'h0000_0020, 3'd2, 2'b01, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
      vecs[4]  = '{1'b0, 4'h7, 32'h0000_0020, 3'd2, 2'b01, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD};
      vecs[5]  = '{1'b0, 4'hA, 32'h0001_0000, 3'd2, 2'b01, 32'h0,         4'h0, 2'b11, 32'h0};
      vecs[6]  = '{1'b1, 4'hB, 32'h0001_0010, 3'd2, 2'b01, 32'h0BAD_F00D, 4'hF, 2'b11, 32'h0};
      vecs[7]  = '{1'b1, 4'hC, 32'h0000_0030, 3'd2, 2'b01, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
      vecs[8]  = '{1'b1, 4'hD, 32'h0000_0030, 3'd1, 2'b01, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
      vecs[9]  = '{1'b0, 4'hE, 32'h0000_0030, 3'd2, 2'b01, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
      vecs[10] = '{1'b0, 4'h1, 32'h0000_0010, 3'd1, 2'b01, 32'h0,         4'h0, 2'b10, 32'h0};
      vecs[11] = '{1'b0, 4'h2, 32'h0000_0012, 3'd2, 2'b10, 32'h0,         4'h0, 2'b10, 32'hDEAD_BEEF};
      vecs[12] = '{1'b1, 4'h4, 32'h0000_0040, 3'd2, 2'b11, 32'h0000_0077, 4'hF, 2'b10, 32'h0};
      vecs[13] = '{1'b0, 4'h6, 32'h0000_0040, 3'd2, 2'b01, 32'h0,         4'h0, 2'b00, 32'h0000_0077};
      vecs[14] = '{1'b0, 4'h8, 32'hFFFF_FFFC, 3'd2, 2'b01, 32'h0,         4'h0, 2'b11, 32'h0};
      vecs[15] = '{1'b1, 4'h9, 32'hFFFF_FFF0, 3'd2, 2'b01, 32'h1111_1111, 4'hF, 2'b11, 32'h0};
      vecs[16] = '{1'b0, 4'h3, 32'h0000_0010, 3'd2, 2'b00, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};

      reset = 1'b1;
      axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd2; axi.awburst = 2'b01;
      axi.awlock = 1'b0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2; axi.arburst = 2'b01;
      axi.arlock = 1'b0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("rst_awready", 32'(axi.awready), 32'd1);
      chk("rst_arready", 32'(axi.arready), 32'd1);
      chk("rst_wready",  32'(axi.wready),  32'd0);
      chk("rst_bvalid",  32'(axi.bvalid),  32'd0);
      chk("rst_rvalid",  32'(axi.rvalid),  32'd0);
      chk("rst_bid",     32'(axi.bid),     32'd0);
      chk("rst_bresp",   32'(axi.bresp),   32'd0);
      chk("rst_rid",     32'(axi.rid),     32'd0);
      chk("rst_rdata",   axi.rdata,        32'd0);
      chk("rst_rresp",   32'(axi.rresp),   32'd0);
      chk("rst_rlast",   32'(axi.rlast),   32'd0);
      axi.awvalid = 1'b1;
      #1;
      chk("rst_arready_awv", 32'(axi.arready), 32'd0);
      chk("rst_awready_awv", 32'(axi.awready), 32'd1);
      axi.awvalid = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wr) begin
            wd[0] = vecs[i].data; ws[0] = vecs[i].strb;
            do_write(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, 1, 0, resp, bid, waits);
            chk($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            chk($sformatf("v%0d_bid", i),   32'(bid),  32'(vecs[i].id));
            chk($sformatf("v%0d_wlat", i),  32'(waits), 32'd0);
         end else begin
            do_read(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, 1, -1, 0, waits);
            chk($sformatf("v%0d_rdata", i), rd[0], vecs[i].exp_data);
            chk($sformatf("v%0d_rresp", i), 32'(rr[0]), 32'(vecs[i].exp_resp));
            chk($sformatf("v%0d_rlast", i), 32'(rl[0]), 32'd1);
            chk($sformatf("v%0d_rid", i),   32'(rids[0]), 32'(vecs[i].id));
            chk($sformatf("v%0d_rlat", i),  32'(waits), 32'd0);
         end
      end

      // INCR 4-beat write then read with a 3-cycle stall on beat 2
      for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
      do_write(4'h6, 32'h100, 8'd3, 3'd2, 2'b01, 4, 3, resp, bid, waits);
      chk("incr_bresp", 32'(resp), 32'd0);
      chk("incr_wlat", 32'(waits), 32'd0);
      do_read(4'h9, 32'h100, 8'd3, 3'd2, 2'b01, 4, 1, 3, waits);
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("incr_rdata%0d", b), rd[b], 32'(b + 1));
         chk($sformatf("incr_rlast%0d", b), 32'(rl[b]), (b == 3) ? 32'd1 : 32'd0);
         chk($sformatf("incr_rresp%0d", b), 32'(rr[b]), 32'd0);
      end
      chk("incr_rlat", 32'(waits), 32'd0);
      chk("incr_stall_stable", 32'(stable_bad), 32'd0);

      // FIXED 3-beat write lands all beats on one word; a FIXED read re-reads it
      wd[0] = 32'd5; wd[1] = 32'd6; wd[2] = 32'd7;
      ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'hF;
      do_write(4'h2, 32'h200, 8'd2, 3'd2, 2'b00, 3, 2, resp, bid, waits);
      chk("fixed_bresp", 32'(resp), 32'd0);
      do_read(4'h2, 32'h200, 8'd1, 3'd2, 2'b00, 2, -1, 0, waits);
      chk("fixed_rdata0", rd[0], 32'd7);
      chk("fixed_rdata1", rd[1], 32'd7);
      chk("fixed_rlast0", 32'(rl[0]), 32'd0);
      chk("fixed_rlast1", 32'(rl[1]), 32'd1);

      // early wlast: error, but the burst still runs its two beats and commits both
      wd[0] = 32'hA1; wd[1] = 32'hA2; ws[0] = 4'hF; ws[1] = 4'hF;
      do_write(4'h5, 32'h300, 8'd1, 3'd2, 2'b01, 2, 0, resp, bid, waits);
      chk("wlast_early_bresp", 32'(resp), 32'd2);
      chk("wlast_early_lat", 32'(waits), 32'd0);
      do_read(4'h5, 32'h300, 8'd1, 3'd2, 2'b01, 2, -1, 0, waits);
      chk("wlast_early_rd0", rd[0], 32'hA1);
      chk("wlast_early_rd1", rd[1], 32'hA2);
      do_write(4'h5, 32'h308, 8'd1, 3'd2, 2'b01, 2, -1, resp, bid, waits);
      chk("wlast_missing_bresp", 32'(resp), 32'd2);

      // simultaneous AW and AR: write first, read only after B completes
      axi.awid = 4'hF; axi.awaddr = 32'h400; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'b01;
      axi.arid = 4'h1; axi.araddr = 32'h400; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'b01;
      axi.awvalid = 1'b1; axi.arvalid = 1'b1;
      @(negedge clk);
      chk("arb_awready", 32'(axi.awready), 32'd1);
      chk("arb_arready", 32'(axi.arready), 32'd0);
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      @(negedge clk);
      chk("arb_arready_wdata", 32'(axi.arready), 32'd0);
      axi.wdata = 32'h5A5A_0001; axi.wstrb = 4'hF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
      @(posedge clk); #1;
      axi.wvalid = 1'b0; axi.wlast = 1'b0;
      @(negedge clk);
      chk("arb_bvalid", 32'(axi.bvalid), 32'd1);
      chk("arb_arready_wresp", 32'(axi.arready), 32'd0);
      chk("arb_bid", 32'(axi.bid), 32'hF);
      axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0;
      @(negedge clk);
      chk("arb_arready_idle", 32'(axi.arready), 32'd1);
      @(posedge clk); #1;
      axi.arvalid = 1'b0; axi.rready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!axi.rvalid && n < 50) begin n++; @(negedge clk); end
      chk("arb_rlat", 32'(n), 32'd1);
      chk("arb_rdata", axi.rdata, 32'h5A5A_0001);
      chk("arb_rid", 32'(axi.rid), 32'h1);
      @(posedge clk); #1;
      axi.rready = 1'b0;

      // reset while parked in R_DATA
      axi.arid = 4'h4; axi.araddr = 32'h10; axi.arlen = 8'd0; axi.arburst = 2'b01; axi.arvalid = 1'b1;
      @(posedge clk); #1;
      axi.arvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!axi.rvalid && n < 50) begin n++; @(negedge clk); end
      chk("rstmid_rvalid_before", 32'(axi.rvalid), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rstmid_rvalid", 32'(axi.rvalid), 32'd0);
      chk("rstmid_arready", 32'(axi.arready), 32'd1);
      chk("rstmid_rdata", axi.rdata, 32'd0);
      chk("rstmid_rlast", 32'(axi.rlast), 32'd0);
      @(posedge clk); #1;
      do_read(4'h7, 32'h10, 8'd0, 3'd2, 2'b01, 1, -1, 0, waits);
      chk("rstmid_newread", rd[0], 32'hDEAD_BEEF);
      chk("rstmid_newread_resp", 32'(rr[0]), 32'd0);
      chk("rstmid_newread_lat", 32'(waits), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
